// File: rtl/rr_arb_slice.sv
// Round-robin arbiter feeding a single-entry registered output slice.
// The winner's payload, binary index and one-hot grant are captured together.
module rr_arb_slice #(
    parameter int InputWidth = 8,
    parameter int DataWidth  = 8,
    localparam int IdxWidth  = $clog2(InputWidth)
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [InputWidth-1:0]           req_valid_i,
    input  logic [InputWidth*DataWidth-1:0] req_data_i,
    output logic [InputWidth-1:0]           req_ready_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DataWidth-1:0]            out_data_o,
    output logic [IdxWidth-1:0]             out_idx_o,
    output logic [InputWidth-1:0]           out_oh_o
);

    localparam logic [InputWidth-1:0] OneVec = {{(InputWidth-1){1'b0}}, 1'b1};

    logic [InputWidth-1:0] mask_r;
    logic [InputWidth-1:0] masked_s;
    logic [InputWidth-1:0] grant_s;
    logic [InputWidth-1:0] mask_next_s;
    logic [InputWidth-1:0] req_ready_s;
    logic [IdxWidth-1:0]   grant_idx_s;
    logic [DataWidth-1:0]  grant_data_s;
    logic                  can_load_s;
    logic                  fire_s;

    logic                  out_valid_r;
    logic [DataWidth-1:0]  out_data_r;
    logic [IdxWidth-1:0]   out_idx_r;
    logic [InputWidth-1:0] out_oh_r;

    // Lowest set bit at or above the pointer, else lowest set bit overall (wrap).
    always_comb begin
        masked_s = req_valid_i & mask_r;
        grant_s  = '0;
        if (masked_s != '0) begin
            grant_s = masked_s & ~(masked_s - OneVec);
        end else begin
            grant_s = req_valid_i & ~(req_valid_i - OneVec);
        end
        // Bits strictly above the winner; all-zero when the top requester wins.
        mask_next_s = ~(grant_s | (grant_s - OneVec));
    end

    // Grant is one-hot, so an AND-OR mux yields the winner's index and payload.
    always_comb begin
        grant_idx_s  = '0;
        grant_data_s = '0;
        for (int k = 0; k < InputWidth; k++) begin
            grant_idx_s  = grant_idx_s  | (IdxWidth'(k) & {IdxWidth{grant_s[k]}});
            grant_data_s = grant_data_s | (req_data_i[k*DataWidth +: DataWidth]
                                           & {DataWidth{grant_s[k]}});
        end
    end

    // Handshake: ready only while the slot can take a new entry and reset is released.
    always_comb begin
        can_load_s  = ~out_valid_r | out_ready_i;
        req_ready_s = grant_s & {InputWidth{can_load_s & rstn_i}};
        fire_s      = |(req_valid_i & req_ready_s);
    end

    // Round-robin pointer advances only on an accepted transfer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_r <= '1;
        end else if (fire_s) begin
            mask_r <= mask_next_s;
        end
    end

    // Output slice: load on fire, drop valid on a drain with no refill, else hold.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_oh_r    <= '0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_idx_r   <= grant_idx_s;
            out_oh_r    <= grant_s;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    assign req_ready_o = req_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_idx_o   = out_idx_r;
    assign out_oh_o    = out_oh_r;

endmodule

// File: tb/tb_rr_arb_slice.sv
// Directed self-checking bench for rr_arb_slice with four 8-bit requesters.
module tb_rr_arb_slice;

    logic        clk_i;
    logic        rstn_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic [1:0]  out_idx_o;
    logic [3:0]  out_oh_o;

    int n_checks;
    int n_fail;

    rr_arb_slice #(
        .InputWidth(4),
        .DataWidth (8)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .req_valid_i(req_valid_i),
        .req_data_i (req_data_i),
        .req_ready_o(req_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_idx_o  (out_idx_o),
        .out_oh_o   (out_oh_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        req_valid_i = 4'b1111;
        req_data_i  = 32'h44332211;
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_o);
        end
        n_checks++;
        if ({out_data_o, out_idx_o, out_oh_o} !== 14'd0) begin
            n_fail++; $display("FAIL reset_fields: got data=%h idx=%0d oh=%b want 0",
                               out_data_o, out_idx_o, out_oh_o);
        end
        rstn_i = 1'b1;
        #1;
    endtask

    task automatic test_alternate();
        logic [7:0] exp_data [4];
        logic [1:0] exp_idx  [4];
        exp_data = '{8'h10, 8'h32, 8'h10, 8'h32};
        exp_idx  = '{2'd0, 2'd2, 2'd0, 2'd2};
        req_valid_i = 4'b0101;
        req_data_i  = 32'h00320010;
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL alt_first: got ready=%b valid=%b want 0001/0",
                               req_ready_o, out_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_data[i] || out_idx_o !== exp_idx[i]) begin
                n_fail++; $display("FAIL alt_seq[%0d]: got v=%b data=%h idx=%0d want 1/%h/%0d",
                                   i, out_valid_o, out_data_o, out_idx_o, exp_data[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] e_idx;
        do_reset();
        req_valid_i = 4'b1111;
        req_data_i  = 32'h43424140;
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            e_idx = 2'(i % 4);
            n_checks++;
            if (out_idx_o !== e_idx || out_oh_o !== (4'b0001 << e_idx)
                || out_data_o !== (8'h40 + 8'(e_idx))) begin
                n_fail++; $display("FAIL wrap_seq[%0d]: got idx=%0d oh=%b data=%h want idx=%0d",
                                   i, out_idx_o, out_oh_o, out_data_o, e_idx);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid_i = 4'b0010;
        req_data_i  = 32'h3322A511;
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_idx_o !== 2'd1) begin
            n_fail++; $display("FAIL bp_load: got v=%b data=%h idx=%0d want 1/a5/1",
                               out_valid_o, out_data_o, out_idx_o);
        end
        out_ready_i = 1'b0;
        req_valid_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (req_ready_o !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready_o);
            end
            tick();
            n_checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_idx_o !== 2'd1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b data=%h idx=%0d want 1/a5/1",
                                   i, out_valid_o, out_data_o, out_idx_o);
            end
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 0100", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h22 || out_idx_o !== 2'd2) begin
            n_fail++; $display("FAIL bp_release_out: got v=%b data=%h idx=%0d want 1/22/2",
                               out_valid_o, out_data_o, out_idx_o);
        end
    endtask

    task automatic test_idle();
        req_valid_i = 4'b0000;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL idle_ready: got %b want 0000", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0 || out_idx_o !== 2'd2) begin
            n_fail++; $display("FAIL idle_drain: got v=%b idx=%0d want 0/2", out_valid_o, out_idx_o);
        end
        tick();
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_stay: got v=%b want 0", out_valid_o);
        end
        // Pointer still sits after idx2, so idx3 must beat idx0.
        req_valid_i = 4'b1001;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b1000) begin
            n_fail++; $display("FAIL idle_ptr: got %b want 1000", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'h33 || out_idx_o !== 2'd3) begin
            n_fail++; $display("FAIL idle_idx3: got v=%b data=%h idx=%0d want 1/33/3",
                               out_valid_o, out_data_o, out_idx_o);
        end
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++; $display("FAIL idle_wrap_ready: got %b want 0001", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_data_o !== 8'h11 || out_idx_o !== 2'd0) begin
            n_fail++; $display("FAIL idle_wrap_out: got data=%h idx=%0d want 11/0",
                               out_data_o, out_idx_o);
        end
    endtask

    task automatic test_preempt();
        req_valid_i = 4'b0010;
        req_data_i  = 32'h33225A11;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0010) begin
            n_fail++; $display("FAIL pre_win1_ready: got %b want 0010", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_idx_o !== 2'd1 || out_data_o !== 8'h5A) begin
            n_fail++; $display("FAIL pre_win1: got idx=%0d data=%h want 1/5a", out_idx_o, out_data_o);
        end
        out_ready_i = 1'b0;
        req_valid_i = 4'b0001;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL pre_stall0: got %b want 0000", req_ready_o);
        end
        tick();
        req_valid_i = 4'b0101;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL pre_stall1: got %b want 0000", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_idx_o !== 2'd1) begin
            n_fail++; $display("FAIL pre_hold: got v=%b idx=%0d want 1/1", out_valid_o, out_idx_o);
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0100) begin
            n_fail++; $display("FAIL pre_grant2: got %b want 0100", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_idx_o !== 2'd2 || out_data_o !== 8'h22) begin
            n_fail++; $display("FAIL pre_out2: got idx=%0d data=%h want 2/22", out_idx_o, out_data_o);
        end
        req_valid_i = 4'b0001;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0001) begin
            n_fail++; $display("FAIL pre_grant0: got %b want 0001", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_idx_o !== 2'd0 || out_data_o !== 8'h11 || out_oh_o !== 4'b0001) begin
            n_fail++; $display("FAIL pre_out0: got idx=%0d data=%h oh=%b want 0/11/0001",
                               out_idx_o, out_data_o, out_oh_o);
        end
    endtask

    task automatic test_reset_mid();
        req_valid_i = 4'b1111;
        out_ready_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || {out_data_o, out_idx_o, out_oh_o} !== 14'd0
            || req_ready_o !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset: got v=%b data=%h idx=%0d oh=%b rdy=%b want all 0",
                               out_valid_o, out_data_o, out_idx_o, out_oh_o, req_ready_o);
        end
        req_valid_i = 4'b1010;
        tick();
        rstn_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 4'b0010) begin
            n_fail++; $display("FAIL mid_release_ready: got %b want 0010", req_ready_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_idx_o !== 2'd1 || out_data_o !== 8'h5A) begin
            n_fail++; $display("FAIL mid_release_out: got v=%b idx=%0d data=%h want 1/1/5a",
                               out_valid_o, out_idx_o, out_data_o);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn_i      = 1'b0;
        req_valid_i = 4'b0000;
        req_data_i  = 32'h00000000;
        out_ready_i = 1'b0;
        test_reset();
        test_alternate();
        test_wrap();
        test_backpressure();
        test_idle();
        test_preempt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_slice.md
Name: rr_arb_slice

Overview:
- N-way round-robin arbiter with a registered output slice.
- Each requester presents a valid/ready channel with a DataWidth payload. One request is granted per cycle and its payload plus source index are captured into a single-entry output register.
- Sits directly upstream of the one-hot/priority mux stage. Its registered payload and one-hot grant feed that stage or an equivalent consumer.
- Provides fairness: no requester starves, unlike a fixed lowest-index-wins select.

Parameters:
- InputWidth, 8, number of requesters (>=2).
- DataWidth, 8, payload width per requester.
- IdxWidth, $clog2(InputWidth), width of the binary source index (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  InputWidth  per-requester valid.
- req_data_i  in  InputWidth*DataWidth  packed payloads; requester k occupies bits [k*DataWidth +: DataWidth].
- req_ready_o  out  InputWidth  per-requester ready; at most one bit set.
- out_valid_o  out  1  output register holds a valid entry.
- out_ready_i  in  1  downstream accepts the entry.
- out_data_o  out  DataWidth  registered payload.
- out_idx_o  out  IdxWidth  registered binary index of the source requester.
- out_oh_o  out  InputWidth  registered one-hot of the source requester.

Behaviour:
- Reset (rstn_i low, asynchronous): out_valid_o=0, out_data_o=0, out_idx_o=0, out_oh_o=0, priority mask = all ones (requester 0 highest). While in reset, req_ready_o=0.
- Slot free: can_load = ~out_valid_o | out_ready_i. The output register holds one entry; the slot is freed and refilled in the same cycle, so throughput is one transfer per cycle.
- Grant (combinational):
  - masked = req_valid_i & mask.
  - If masked != 0, grant = masked & ~(masked-1); otherwise grant = req_valid_i & ~(req_valid_i-1).
  - grant is one-hot or zero.
- req_ready_o = grant & {InputWidth{can_load}}.
  - req_ready_o depends on req_valid_i; there is no combinational path from out_ready_i to req_ready_o other than through can_load.
- Accept: fire = |(req_valid_i & req_ready_o).
- On fire, the register loads:
  - out_data_o = payload of the granted requester;
  - out_idx_o = binary encoding of grant;
  - out_oh_o = grant;
  - out_valid_o = 1.
- Latency: a request accepted in cycle n appears on the outputs in cycle n+1.
- Output drain: if out_valid_o & out_ready_i & ~fire, out_valid_o is cleared next cycle. out_data_o, out_idx_o and out_oh_o hold their last values; they are don't-care when invalid.
- Back-pressure: if out_valid_o & ~out_ready_i, then req_ready_o=0 and all output fields hold stable.
- Pointer update: only on fire, for winner index w, mask = bits strictly above w (mask[j]=1 for j>w).
  - When w = InputWidth-1, mask becomes 0, so the next grant falls through to the unmasked search starting from requester 0 (wrap-around).
  - No pointer change on cycles without fire.
- Upstream rule: a requester's valid and data stay stable until its ready is seen. The grant may move to a newly arriving requester that is ahead in round-robin order before the original requester is accepted; this is legal.
- Single requester: it is granted every cycle the slot is free; mask updates have no effect on the outcome.
- All-idle: grant=0, req_ready_o=0, pointer held.
- Reset mid-transfer: output entry discarded, pointer returns to requester 0 highest. No partial state survives.

Test Plan (InputWidth=4, DataWidth=8):
- Reset, then req_valid_i=4'b0101 with data0=0x10 and data2=0x32 held, out_ready_i=1.
  - Outputs in order: 0x10 (idx0), 0x32 (idx2), 0x10, 0x32, ...
  - One transfer per cycle, first out_valid_o one cycle after the first accept.
- req_valid_i=4'b1111 held, out_ready_i=1 → out_idx_o sequence 0,1,2,3,0,1 (wrap from 3 to 0 verified).
- Back-pressure:
  - Load idx1 with data 0xA5, then out_ready_i=0 for 5 cycles with req_valid_i=4'b1111.
  - out_valid_o=1 and out_data_o=0xA5 stay stable; req_ready_o=0 throughout.
  - On release: 0xA5 drains, and in the same cycle idx2 is accepted.
- Idle and single-bubble:
  - req_valid_i=0 for 3 cycles → out_valid_o falls 1 cycle after the last transfer drains; the pointer is unchanged.
  - Next request from idx3 alone is granted immediately.
- Preemption by ordering:
  - After a win by idx1, present idx0, then idx2 one cycle later while out_ready_i=0.
  - When out_ready_i rises, idx2 is granted before idx0.
- Assert rstn_i low mid-stream with out_valid_o=1 → outputs zero immediately (asynchronous).
  - After release with req_valid_i=4'b1010, idx1 wins first.
